// File: rtl/sum_display_pkg.sv
// Shared definitions for the sum_display output stage: FSM states, digit
// count, blank pattern and the active-low seven-segment glyph table
// ({g,f,e,d,c,b,a}, 0 = segment lit).
package sum_display_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_CONVERT = 1'b1
  } state_e;

  localparam int unsigned NUM_DIGITS  = 4;
  localparam int unsigned DIGIT_IDX_W = $clog2(NUM_DIGITS);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1000000, // 0
    7'b1111001, // 1
    7'b0100100, // 2
    7'b0110000, // 3
    7'b0011001, // 4
    7'b0010010, // 5
    7'b0000010, // 6
    7'b1111000, // 7
    7'b0000000, // 8
    7'b0010000, // 9
    7'b0001000, // A
    7'b0000011, // b
    7'b1000110, // C
    7'b0100001, // d
    7'b0000110, // E
    7'b0001110  // F
  };

endpackage

// File: rtl/seg7_hex.sv
// Combinational 4-bit to seven-segment decoder, active-low outputs.
//   hex_i : nibble to display (0..F)
//   seg_o : segment cathodes {g,f,e,d,c,b,a}, 0 = lit
module seg7_hex
  import sum_display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_HEX[hex_i];
  end

endmodule

// File: rtl/sum_display.sv
// Output stage after the 4-bit CLA adder. Captures one result {C4,S} with its
// operands, converts the sum to two BCD digits by sequential double-dabble,
// and drives a 4-digit multiplexed seven-segment display:
//   digit 3 = A (hex), digit 2 = B (hex), digit 1 = sum tens, digit 0 = units.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   valid_in          : A_in/B_in/S_in/C4_in valid this cycle
//   ready_out         : high while idle (a new result can be accepted)
//   A_in, B_in        : operands, shown as hex
//   S_in, C4_in       : adder result, sum value = {C4_in, S_in}
//   an_out            : digit enables, active-low one-hot
//   seg_out           : segment cathodes, active-low {g,f,e,d,c,b,a}
module sum_display
  import sum_display_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic [3:0] A_in,
  input  logic [3:0] B_in,
  input  logic [3:0] S_in,
  input  logic       C4_in,
  output logic [3:0] an_out,
  output logic [6:0] seg_out
);

  localparam int unsigned CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);

  state_e           state_q,  state_d;
  logic [3:0]       a_sh_q,   a_sh_d;
  logic [3:0]       b_sh_q,   b_sh_d;
  logic [4:0]       sum_sh_q, sum_sh_d;
  logic [3:0]       tens_q,   tens_d;
  logic [3:0]       units_q,  units_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [3:0]       disp_a_q, disp_a_d;
  logic [3:0]       disp_b_q, disp_b_d;
  logic [3:0]       disp_t_q, disp_t_d;
  logic [3:0]       disp_u_q, disp_u_d;
  logic [CW-1:0]    ref_cnt_q, ref_cnt_d;
  logic [DIGIT_IDX_W-1:0] dig_idx_q, dig_idx_d;
  logic [3:0]       an_q,     an_d;
  logic [6:0]       seg_q,    seg_d;

  logic [3:0] adj_t, adj_u, tens_sh, units_sh;
  logic [3:0] nibble;
  logic [6:0] dec_seg;

  // Double-dabble step: add-3 correction, then shift {tens, units, sum} left.
  always_comb begin
    adj_t    = (tens_q  >= 4'd5) ? tens_q  + 4'd3 : tens_q;
    adj_u    = (units_q >= 4'd5) ? units_q + 4'd3 : units_q;
    tens_sh  = {adj_t[2:0], adj_u[3]};
    units_sh = {adj_u[2:0], sum_sh_q[4]};
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    tens_d   = tens_q;
    units_d  = units_q;
    bitcnt_d = bitcnt_q;
    disp_a_d = disp_a_q;
    disp_b_d = disp_b_q;
    disp_t_d = disp_t_q;
    disp_u_d = disp_u_q;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          a_sh_d   = A_in;
          b_sh_d   = B_in;
          sum_sh_d = {C4_in, S_in};
          tens_d   = '0;
          units_d  = '0;
          bitcnt_d = 3'd4;
          state_d  = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        tens_d   = tens_sh;
        units_d  = units_sh;
        sum_sh_d = {sum_sh_q[3:0], 1'b0};
        bitcnt_d = bitcnt_q - 3'd1;
        if (bitcnt_q == 3'd0) begin
          // Last shift: commit the post-shift digits directly.
          bitcnt_d = '0;
          disp_a_d = a_sh_q;
          disp_b_d = b_sh_q;
          disp_t_d = tens_sh;
          disp_u_d = units_sh;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Refresh timing and registered digit drive; an/seg update together.
  always_comb begin
    ref_cnt_d = ref_cnt_q + 1'b1;
    dig_idx_d = dig_idx_q;
    if (ref_cnt_q == CNT_LAST) begin
      ref_cnt_d = '0;
      dig_idx_d = dig_idx_q + 1'b1;
    end
    unique case (dig_idx_q)
      2'd0:    nibble = disp_u_q;
      2'd1:    nibble = disp_t_q;
      2'd2:    nibble = disp_b_q;
      default: nibble = disp_a_q;
    endcase
    an_d  = ~(4'b0001 << dig_idx_q);
    seg_d = ((dig_idx_q == 2'd1) && (disp_t_q == 4'd0)) ? SEG_BLANK : dec_seg;
  end

  seg7_hex u_dec (
    .hex_i (nibble),
    .seg_o (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_sh_q  <= '0;
      tens_q    <= '0;
      units_q   <= '0;
      bitcnt_q  <= '0;
      disp_a_q  <= '0;
      disp_b_q  <= '0;
      disp_t_q  <= '0;
      disp_u_q  <= '0;
      ref_cnt_q <= '0;
      dig_idx_q <= '0;
      an_q      <= 4'b1110;
      seg_q     <= SEG_HEX[0];
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      sum_sh_q  <= sum_sh_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      bitcnt_q  <= bitcnt_d;
      disp_a_q  <= disp_a_d;
      disp_b_q  <= disp_b_d;
      disp_t_q  <= disp_t_d;
      disp_u_q  <= disp_u_d;
      ref_cnt_q <= ref_cnt_d;
      dig_idx_q <= dig_idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign ready_out = (state_q == ST_IDLE);
  assign an_out    = an_q;
  assign seg_out   = seg_q;

endmodule

// File: tb/tb_sum_display.sv
module tb_sum_display;

  localparam int DC = 4;

  logic       clk;
  logic       rst_n;
  logic       valid_in;
  logic       ready_out;
  logic [3:0] A_in, B_in, S_in;
  logic       C4_in;
  logic [3:0] an_out;
  logic [6:0] seg_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] cap_seg [4];
  bit         cap_seen [4];

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    string      name;
    logic [3:0] a, b, s;
    logic       c4;
    logic [6:0] e3, e2, e1, e0;
  } vec_t;

  sum_display #(.DIGIT_CYCLES(DC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .A_in      (A_in),
    .B_in      (B_in),
    .S_in      (S_in),
    .C4_in     (C4_in),
    .an_out    (an_out),
    .seg_out   (seg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (ready_out !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("wait_ready", {31'd0, ready_out}, 32'd1);
  endtask

  // Accept one result and verify ready_out stays low for exactly 5 cycles.
  task automatic do_accept(input string name, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] s, input logic c4);
    int busy;
    wait_ready();
    A_in = a; B_in = b; S_in = s; C4_in = c4; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    busy = 0;
    while (ready_out === 1'b0 && busy < 20) begin
      busy++;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, busy, 5);
  endtask

  // Observe one full refresh period; check one-hot an_out and switch spacing.
  task automatic capture();
    int since;
    int changes;
    logic [3:0] prev;
    for (int i = 0; i < 4; i++) cap_seen[i] = 1'b0;
    since = 0; changes = 0; prev = an_out;
    for (int c = 0; c < 4 * DC + 4; c++) begin
      @(negedge clk);
      since++;
      if (an_out !== prev) begin
        if (changes > 0) chk("digit_switch_spacing", since, DC);
        changes++;
        since = 0;
        prev = an_out;
      end
      n_checks++;
      case (an_out)
        4'b1110: begin cap_seg[0] = seg_out; cap_seen[0] = 1'b1; end
        4'b1101: begin cap_seg[1] = seg_out; cap_seen[1] = 1'b1; end
        4'b1011: begin cap_seg[2] = seg_out; cap_seen[2] = 1'b1; end
        4'b0111: begin cap_seg[3] = seg_out; cap_seen[3] = 1'b1; end
        default: begin
          n_fail++;
          $display("FAIL an_onehot: got %b expected one-hot low", an_out);
        end
      endcase
    end
  endtask

  task automatic check_digits(input string name, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    capture();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s_digit%0d_seen", name, d), {31'd0, cap_seen[d]}, 32'd1);
      chk($sformatf("%s_digit%0d_seg", name, d), {25'd0, cap_seg[d]}, {25'd0, exp[d]});
    end
  endtask

  task automatic model_check(input string name, input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] s, input logic c4);
    int sum, tens, units;
    logic [6:0] e1;
    sum   = int'({c4, s});
    tens  = sum / 10;
    units = sum % 10;
    e1    = (tens == 0) ? 7'b1111111 : glyph[tens];
    do_accept(name, a, b, s, c4);
    check_digits(name, glyph[a], glyph[b], e1, glyph[units]);
  endtask

  initial begin
    vec_t vecs [3];
    logic [3:0] ra, rb, rs;
    logic rc;

    vecs[0] = '{"sum18", 4'b1010, 4'b0111, 4'b0010, 1'b1,
                7'b0001000, 7'b1111000, 7'b1111001, 7'b0000000};
    vecs[1] = '{"sum31", 4'b1111, 4'b1111, 4'b1111, 1'b1,
                7'b0001110, 7'b0001110, 7'b0110000, 7'b1111001};
    vecs[2] = '{"sum0", 4'b0000, 4'b0000, 4'b0000, 1'b0,
                7'b1000000, 7'b1000000, 7'b1111111, 7'b1000000};

    rst_n = 1'b0; valid_in = 1'b0;
    A_in = '0; B_in = '0; S_in = '0; C4_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, ready_out}, 32'd1);
    chk("reset_an", {28'd0, an_out}, 32'b1110);
    chk("reset_seg", {25'd0, seg_out}, 32'b1000000);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      do_accept(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c4);
      check_digits(vecs[i].name, vecs[i].e3, vecs[i].e2, vecs[i].e1, vecs[i].e0);
    end

    // Asynchronous reset mid-run takes effect without a clock edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_ready", {31'd0, ready_out}, 32'd1);
    chk("async_reset_an", {28'd0, an_out}, 32'b1110);
    chk("async_reset_seg", {25'd0, seg_out}, 32'b1000000);
    @(negedge clk);
    rst_n = 1'b1;
    check_digits("after_reset", 7'b1000000, 7'b1000000, 7'b1111111, 7'b1000000);

    // Busy drop: sum 9 accepted, sum 5 offered at T+2 is ignored.
    wait_ready();
    A_in = 4'h4; B_in = 4'h5; S_in = 4'b1001; C4_in = 1'b0; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    A_in = 4'h2; B_in = 4'h3; S_in = 4'b0101; C4_in = 1'b0; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    chk("busy_drop_ready_low", {31'd0, ready_out}, 32'd0);
    wait_ready();
    @(negedge clk);
    chk("busy_drop_no_reaccept", {31'd0, ready_out}, 32'd1);
    check_digits("busy_drop", glyph[4], glyph[5], 7'b1111111, 7'b0010000);

    // Reset at T+3 during conversion of 18 aborts it.
    wait_ready();
    A_in = 4'b1010; B_in = 4'b0111; S_in = 4'b0010; C4_in = 1'b1; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midconv_reset_ready", {31'd0, ready_out}, 32'd1);
    chk("midconv_reset_seg", {25'd0, seg_out}, 32'b1000000);
    @(negedge clk);
    rst_n = 1'b1;
    check_digits("midconv_zero", 7'b1000000, 7'b1000000, 7'b1111111, 7'b1000000);
    do_accept("sum12", 4'h3, 4'h9, 4'b1100, 1'b0);
    check_digits("sum12", glyph[3], glyph[9], 7'b1111001, 7'b0100100);

    for (int r = 0; r < 10; r++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rs = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      model_check($sformatf("rand%0d", r), ra, rb, rs, rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
